// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax row-read burst scheduler.
package softmax_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_NEXT
  } sched_state_e;

  localparam int BEAT_BYTES = 16;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  // Burst size ladder in beats, largest first.
  localparam int BURST_L = 32;
  localparam int BURST_M = 16;
  localparam int BURST_S = 8;

endpackage

// File: rtl/sig_delay.sv
// Fixed D-cycle delay line for a W-bit signal, cleared by async reset.
module sig_delay #(
  parameter int D = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [D];

  // NOTE: a delay line is control state, not storage; every stage is reset
  // so the first edge seen after reset is measured against a known 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[D-1];

endmodule

// File: rtl/softmax_rd_sched.sv
// Row/burst read scheduler: splits each row into 32/16/8/tail-beat bursts.
// Optional wait-cycle counter enabled by defining SOFTMAX_RD_SCHED_PERF_EN.
module softmax_rd_sched
  import softmax_pkg::*;
#(
  parameter int XAW = 32,
  parameter int LW  = 16,
  parameter int CW  = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_start,
  input  logic [XAW-1:0] cfg_base,
  input  logic [LW-1:0]  cfg_beats,
  input  logic [CW-1:0]  cfg_rows,
  input  logic [XAW-1:0] cfg_stride,
  output logic [XAW-1:0] rmst_read_base,
  output logic [XAW-1:0] rmst_read_length,
  output logic           rmst_go,
  input  logic           rmst_done,
  output logic           row_done,
  output logic           all_done,
  output logic           busy
`ifdef SOFTMAX_RD_SCHED_PERF_EN
  ,
  output logic [31:0]    perf_wait_cycles
`endif
);

  sched_state_e   state_q, state_d;
  logic [LW-1:0]  beats_q, beats_d;
  logic [XAW-1:0] stride_q, stride_d;
  logic [CW-1:0]  rows_left_q, rows_left_d;
  logic [XAW-1:0] row_base_q, row_base_d;
  logic [XAW-1:0] burst_base_q, burst_base_d;
  logic [LW-1:0]  rem_q, rem_d;
  logic [LW-1:0]  burst_q, burst_d;
  logic [XAW-1:0] rd_base_q, rd_base_d;
  logic [XAW-1:0] rd_len_q, rd_len_d;

  logic           done_dly;
  logic           done_edge;
  logic [LW-1:0]  burst_sel;
  logic [LW-1:0]  rem_after;
  logic           job_empty;

  sig_delay #(.D(1), .W(1)) u_done_dly (
    .clk (clk),
    .rst (rst),
    .d_i (rmst_done),
    .q_o (done_dly)
  );

  assign done_edge = rmst_done & ~done_dly;
  assign rem_after = rem_q - burst_q;
  assign job_empty = (rows_left_q == '0) || (beats_q == '0);

  always_comb begin
    if      (rem_q >= LW'(BURST_L)) burst_sel = LW'(BURST_L);
    else if (rem_q >= LW'(BURST_M)) burst_sel = LW'(BURST_M);
    else if (rem_q >= LW'(BURST_S)) burst_sel = LW'(BURST_S);
    else                            burst_sel = rem_q;
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    stride_d     = stride_q;
    rows_left_d  = rows_left_q;
    row_base_d   = row_base_q;
    burst_base_d = burst_base_q;
    rem_d        = rem_q;
    burst_d      = burst_q;
    rd_base_d    = rd_base_q;
    rd_len_d     = rd_len_q;
    rmst_go      = 1'b0;
    row_done     = 1'b0;
    all_done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          beats_d      = cfg_beats;
          stride_d     = cfg_stride;
          rows_left_d  = cfg_rows;
          row_base_d   = cfg_base;
          burst_base_d = cfg_base;
          rem_d        = cfg_beats;
          state_d      = S_CALC;
        end
      end
      S_CALC: begin
        if (job_empty) begin
          all_done = 1'b1;
          state_d  = S_IDLE;
        end else begin
          burst_d   = burst_sel;
          rd_base_d = burst_base_q;
          rd_len_d  = XAW'(burst_sel) << BEAT_SHIFT;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rmst_go = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Edges outside WAIT fall through the other arms and are dropped.
        if (done_edge) begin
          burst_base_d = burst_base_q + rd_len_q;
          rem_d        = rem_after;
          state_d      = (rem_after == '0) ? S_NEXT : S_CALC;
        end
      end
      S_NEXT: begin
        row_done     = 1'b1;
        row_base_d   = row_base_q + stride_q;
        burst_base_d = row_base_q + stride_q;
        rem_d        = beats_q;
        rows_left_d  = rows_left_q - CW'(1);
        if (rows_left_q == CW'(1)) begin
          all_done = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beats_q      <= '0;
      stride_q     <= '0;
      rows_left_q  <= '0;
      row_base_q   <= '0;
      burst_base_q <= '0;
      rem_q        <= '0;
      burst_q      <= '0;
      rd_base_q    <= '0;
      rd_len_q     <= '0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      stride_q     <= stride_d;
      rows_left_q  <= rows_left_d;
      row_base_q   <= row_base_d;
      burst_base_q <= burst_base_d;
      rem_q        <= rem_d;
      burst_q      <= burst_d;
      rd_base_q    <= rd_base_d;
      rd_len_q     <= rd_len_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign rmst_read_base   = rd_base_q;
  assign rmst_read_length = rd_len_q;

`ifdef SOFTMAX_RD_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && cfg_start) begin
      perf_q <= '0;
    end else if (state_q == S_WAIT && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_wait_cycles = perf_q;
`endif

endmodule

// File: doc/softmax_rd_sched.md
SOFTMAX_RD_SCHED -- requirements
Module: softmax_rd_sched

Interface
REQ-001 SHALL have parameter XAW, default 32, meaning the address and length width in bits.
REQ-002 SHALL have parameter LW, default 16, meaning the width of the per-row beat count (1 beat = 128 bits = 16 bytes).
REQ-003 SHALL have parameter CW, default 12, meaning the width of the row count.
REQ-004 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_start  input  1  one-cycle pulse; latches cfg_* and starts a job.
REQ-007 SHALL have port cfg_base  input  XAW  byte address of row 0.
REQ-008 SHALL have port cfg_beats  input  LW  beats per row.
REQ-009 SHALL have port cfg_rows  input  CW  number of rows.
REQ-010 SHALL have port cfg_stride  input  XAW  byte offset between consecutive row bases.
REQ-011 SHALL have port rmst_read_base  output  XAW  burst byte address to the read master.
REQ-012 SHALL have port rmst_read_length  output  XAW  burst length in bytes.
REQ-013 SHALL have port rmst_go  output  1  one-cycle burst launch pulse.
REQ-014 SHALL have port rmst_done  input  1  read master done level; its rising edge ends a burst.
REQ-015 SHALL have port row_done  output  1  one-cycle pulse after the last burst of each row completes.
REQ-016 SHALL have port all_done  output  1  one-cycle pulse when the job completes.
REQ-017 SHALL have port busy  output  1  high from the cycle after cfg_start until the cycle of all_done.

Function
REQ-018 SHALL implement the FSM states IDLE, CALC, ISSUE, WAIT and NEXT.
- IDLE -> CALC on cfg_start.
- CALC -> ISSUE.
- ISSUE -> WAIT.
- WAIT -> CALC on a done edge when row beats remain.
- WAIT -> NEXT on a done edge when the row is exhausted.
- NEXT -> CALC when rows remain, otherwise -> IDLE.
REQ-019 SHALL, in CALC, select the burst size in beats from the row's remaining beats rem:
- rem >= 32 -> 32; rem >= 16 -> 16; rem >= 8 -> 8; else rem.
- rmst_read_length SHALL equal the burst size shifted left by 4.
REQ-020 SHALL assert rmst_go only in ISSUE, for exactly one cycle, with rmst_read_base and rmst_read_length registered and stable from CALC until the next CALC.
REQ-021 SHALL, on each done edge, advance the burst base by the burst length and decrement rem by the burst size, both modulo 2^XAW.
REQ-022 SHALL, in NEXT:
- pulse row_done;
- set the row base to the previous row base plus cfg_stride;
- reload rem with cfg_beats.
REQ-023 SHALL, on the NEXT -> IDLE transition after the final row, pulse all_done coincident with the final row_done.
REQ-024 SHALL give a latency of 2 cycles from the cfg_start cycle to the first rmst_go.
REQ-025 SHALL detect the done edge as rmst_done high in the current cycle and low in the previous cycle; a rising edge outside WAIT SHALL be ignored.
REQ-026 SHALL ignore cfg_start while busy; latched parameters SHALL NOT change mid-job.
REQ-027 SHALL, when cfg_rows == 0 or cfg_beats == 0, issue no rmst_go, no row_done, and pulse all_done one cycle after cfg_start.
REQ-028 SHALL, when rmst_done rises in the same cycle that the FSM enters WAIT, count that edge.

Reset
REQ-029 SHALL, on rst, immediately and mid-job abandon any outstanding burst without waiting for rmst_done and force:
- FSM to IDLE;
- busy, rmst_go, row_done and all_done to 0;
- rmst_read_base and rmst_read_length to 0;
- all counters and the done-edge history register to 0.

Configuration
REQ-030 SHALL, with macro SOFTMAX_RD_SCHED_PERF_EN defined, add output perf_wait_cycles (32 bits):
- counts cycles spent in WAIT;
- clears on cfg_start;
- saturates at 2^32-1;
- resets to 0.
REQ-031 SHALL, without SOFTMAX_RD_SCHED_PERF_EN, omit that port and its counter entirely.

Structure
REQ-032 SHALL place the following in shared package softmax_pkg:
- the FSM state typedef;
- BEAT_BYTES = 16;
- the burst thresholds 32, 16 and 8.
REQ-033 SHALL instantiate one sub-module: the existing sig_delay with D = 1, producing the delayed rmst_done for edge detection.

Verification
REQ-034 SHALL cover a single row: base 0x1000, beats 40, rows 1.
- Two bursts: (0x1000, 512 bytes) then (0x1200, 128 bytes).
- row_done and all_done together after the second done edge.
REQ-035 SHALL cover multiple rows: base 0x0, beats 5, rows 3, stride 0x400.
- Bursts at 0x0, 0x400 and 0x800, each 80 bytes.
- Three row_done pulses; all_done with the third.
REQ-036 SHALL cover an empty job: beats 0, rows 4.
- No rmst_go; all_done one cycle after cfg_start; busy is never visibly high for more than 1 cycle.
REQ-037 SHALL cover cfg_start re-pulsed mid-job with base 0xF000.
- Ignored; job completes on the original parameters.
REQ-038 SHALL cover rst asserted in WAIT, then a rising edge on rmst_done.
- Outputs 0 immediately; the edge is ignored; a new cfg_start gives rmst_go 2 cycles later.
REQ-039 SHALL cover the PERF build, where rmst_done rises 10 cycles after each rmst_go in the single-row job.
- perf_wait_cycles = 20 at all_done.
